// File: rtl/alu_issue_ctrl.sv
// Registered issue front end for the combinational FullALU: one command per handshake, one response per command.
// Optional completed-operation counter output op_count is enabled by defining ALU_ISSUE_OPCNT_EN.
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_aluop,
    input  logic [3:0]       cmd_func,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [1:0]       ALUOp,
    output logic [3:0]       FuncCode,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic             Zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
`ifdef ALU_ISSUE_OPCNT_EN
    output logic [CNT_W-1:0] op_count,
`endif
    output logic             busy
);

    // Both channels use valid/ready: a transfer happens on a rising clk edge
    // where valid and ready are both high; the source holds its payload
    // stable until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       aluop_q, aluop_d;
    logic [3:0]       func_q, func_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic             illegal;

    // Decoded from the registered command so a source changing cmd_* after accept cannot affect it.
    always_comb begin
        illegal = 1'b0;
        if (aluop_q == 2'b11) begin
            illegal = 1'b1;
        end else if (aluop_q == 2'b10) begin
            case (func_q)
                4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010: illegal = 1'b0;
                default:                                     illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        aluop_d      = aluop_q;
        func_d       = func_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    aluop_d = cmd_aluop;
                    func_d  = cmd_func;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_result_d = ALUOut;
                rsp_zero_d   = Zero;
                rsp_err_d    = illegal;
                rsp_valid_d  = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            aluop_q      <= 2'b00;
            func_q       <= 4'b0000;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            aluop_q      <= aluop_d;
            func_q       <= func_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign ALUOp      = aluop_q;
    assign FuncCode   = func_q;
    assign A          = a_q;
    assign B          = b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

`ifdef ALU_ISSUE_OPCNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of response handshakes, illegal commands included.
    always_comb begin
        cnt_d = cnt_q;
        if (rsp_valid_q && rsp_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_count = cnt_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
